// File: rtl/gpreg_scb.sv
// gpreg_scb: general-purpose register file with a load scoreboard.
// Every register has a busy bit. A load issue sets the bit, and a matching
// load return clears it. Stall flags RAW and WAW hazards for the current
// instruction. LdErr pulses for one cycle when a load returns to a tag
// that is not busy.
// Optional feature: define GPREG_BYPASS_EN to forward same-edge write data
// to A/B. With it, Stall also ignores the busy bit of a register whose load
// is returning in the same cycle.
module gpreg_scb #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 3,
   parameter int R0_ZERO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] SelX,
   input  logic [ADDR_W-1:0] SelY,
   input  logic [ADDR_W-1:0] SelZ,
   input  logic [1:0]        MemInstruction,
   input  logic [DATA_W-1:0] MemData,
   input  logic [DATA_W-1:0] AluData,
   input  logic              LdValid,
   input  logic [ADDR_W-1:0] LdTag,
   input  logic [DATA_W-1:0] LdData,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              Stall,
   output logic              LdErr
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_ALU  = 2'b10,
      OP_MEM  = 2'b11
   } memOp_t;

   memOp_t              op;
   logic [DATA_W-1:0]   regs [DEPTH];
   logic [DEPTH-1:0]    busy;
   logic [DEPTH-1:0]    busyView;
   logic                ldHit;
   logic                ldOrphan;
   logic                zLocked;
   logic                opWrite;
   logic                opLoad;
   logic [DATA_W-1:0]   wrData;
   logic [DATA_W-1:0]   readA;
   logic [DATA_W-1:0]   readB;

   assign op = memOp_t'(MemInstruction);

   // Hazard detection and decode of the current instruction
   always_comb begin
      busyView = busy;
`ifdef GPREG_BYPASS_EN
      // A returning load resolves its own hazard in the same cycle
      if (LdValid) busyView[LdTag] = 1'b0;
`endif
      Stall    = busyView[SelX] | busyView[SelY] |
                 ((op != OP_NOP) & busyView[SelZ]);
      ldHit    = LdValid & busy[LdTag];
      ldOrphan = LdValid & ~busy[LdTag];
      zLocked  = (R0_ZERO != 0) && (SelZ == '0);
      opWrite  = ~Stall & ((op == OP_ALU) | (op == OP_MEM)) & ~zLocked;
      opLoad   = ~Stall & (op == OP_LOAD) & ~zLocked;
      wrData   = (op == OP_ALU) ? AluData : MemData;
   end

   // Read-port data selection, optionally forwarding same-edge writes
   always_comb begin
      readA = regs[SelX];
      readB = regs[SelY];
`ifdef GPREG_BYPASS_EN
      // Op write takes priority over a load return, matching the array update
      if (ldHit && (LdTag == SelX)) readA = LdData;
      if (ldHit && (LdTag == SelY)) readB = LdData;
      if (opWrite && (SelZ == SelX)) readA = wrData;
      if (opWrite && (SelZ == SelY)) readB = wrData;
`endif
      if ((R0_ZERO != 0) && (SelX == '0)) readA = '0;
      if ((R0_ZERO != 0) && (SelY == '0)) readB = '0;
   end

   // Register array and busy bits: op write beats load return, issue beats clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (opWrite && (SelZ == ADDR_W'(i))) begin
               regs[i] <= wrData;
               busy[i] <= 1'b0;
            end else begin
               if (ldHit && (LdTag == ADDR_W'(i))) regs[i] <= LdData;
               if (opLoad && (SelZ == ADDR_W'(i)))
                  busy[i] <= 1'b1;
               else if (ldHit && (LdTag == ADDR_W'(i)))
                  busy[i] <= 1'b0;
            end
         end
      end
   end

   // Registered read ports and orphan-return pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         A     <= '0;
         B     <= '0;
         LdErr <= 1'b0;
      end else begin
         A     <= readA;
         B     <= readB;
         LdErr <= ldOrphan;
      end
   end

endmodule

// File: tb/tb_gpreg_scb.sv
// Directed self-checking bench for gpreg_scb (default and R0_ZERO=1 instances).
module tb_gpreg_scb;

   localparam int DW = 32;
   localparam int AW = 3;

`ifdef GPREG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] SelX, SelY, SelZ, LdTag;
   logic [1:0]    MemInstruction;
   logic [DW-1:0] MemData, AluData, LdData;
   logic          LdValid;
   logic [DW-1:0] A, B;
   logic          Stall, LdErr;

   logic [AW-1:0] zSelX, zSelY, zSelZ;
   logic [1:0]    zOp;
   logic [DW-1:0] zMem;
   logic [DW-1:0] zA, zB;
   logic          zStall, zLdErr;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   gpreg_scb #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(0)) dut (
      .clk(clk), .rst(rst), .SelX(SelX), .SelY(SelY), .SelZ(SelZ),
      .MemInstruction(MemInstruction), .MemData(MemData), .AluData(AluData),
      .LdValid(LdValid), .LdTag(LdTag), .LdData(LdData),
      .A(A), .B(B), .Stall(Stall), .LdErr(LdErr)
   );

   gpreg_scb #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(1)) dutZ (
      .clk(clk), .rst(rst), .SelX(zSelX), .SelY(zSelY), .SelZ(zSelZ),
      .MemInstruction(zOp), .MemData(zMem), .AluData('0),
      .LdValid(1'b0), .LdTag('0), .LdData('0),
      .A(zA), .B(zB), .Stall(zStall), .LdErr(zLdErr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      SelX = '0; SelY = '0; SelZ = '0; LdTag = '0;
      MemInstruction = 2'b00; MemData = '0; AluData = '0; LdData = '0; LdValid = 1'b0;
      zSelX = '0; zSelY = '0; zSelZ = '0; zOp = 2'b00; zMem = '0;
      #2;
      tests++; if (A !== '0) begin failed++; $display("FAIL reset_A: got %h expected 0", A); end
      tests++; if (B !== '0) begin failed++; $display("FAIL reset_B: got %h expected 0", B); end
      tests++; if (Stall !== 1'b0) begin failed++; $display("FAIL reset_Stall: got %b expected 0", Stall); end
      tests++; if (LdErr !== 1'b0) begin failed++; $display("FAIL reset_LdErr: got %b expected 0", LdErr); end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      MemInstruction = 2'b11; SelZ = 3'd0; MemData = 32'd55; tick();
      SelZ = 3'd1; MemData = 32'd44; tick();
      SelZ = 3'd2; MemData = 32'd37; tick();
      MemInstruction = 2'b00; SelX = 3'd1; SelY = 3'd2; tick();
      tests++; if (A !== 32'd44) begin failed++; $display("FAIL rd_A_r1: got %0d expected 44", A); end
      tests++; if (B !== 32'd37) begin failed++; $display("FAIL rd_B_r2: got %0d expected 37", B); end
      SelX = 3'd0; tick();
      tests++; if (A !== 32'd55) begin failed++; $display("FAIL rd_A_r0: got %0d expected 55", A); end
   endtask

   task automatic test_load();
      MemInstruction = 2'b01; SelZ = 3'd3; SelX = 3'd0; SelY = 3'd0; #1;
      tests++; if (Stall !== 1'b0) begin failed++; $display("FAIL ld_issue_stall: got %b expected 0", Stall); end
      tick();
      MemInstruction = 2'b00; SelX = 3'd3; #1;
      tests++; if (Stall !== 1'b1) begin failed++; $display("FAIL ld_raw_stall: got %b expected 1", Stall); end
      MemInstruction = 2'b10; AluData = 32'h123; SelZ = 3'd3; SelX = 3'd1; SelY = 3'd1; #1;
      tests++; if (Stall !== 1'b1) begin failed++; $display("FAIL ld_waw_stall: got %b expected 1", Stall); end
      tick();
      MemInstruction = 2'b00; LdValid = 1'b1; LdTag = 3'd3; LdData = 32'hDEADBEEF; SelX = 3'd3; #1;
      tests++; if (Stall !== !BYP) begin failed++; $display("FAIL ld_ret_stall: got %b expected %b", Stall, !BYP); end
      tick();
      LdValid = 1'b0; #1;
      tests++; if (Stall !== 1'b0) begin failed++; $display("FAIL ld_clear_stall: got %b expected 0", Stall); end
      tests++; if (A !== (BYP ? 32'hDEADBEEF : 32'h0)) begin failed++; $display("FAIL ld_A_edge: got %h expected %h", A, (BYP ? 32'hDEADBEEF : 32'h0)); end
      tests++; if (LdErr !== 1'b0) begin failed++; $display("FAIL ld_no_err: got %b expected 0", LdErr); end
      tick();
      tests++; if (A !== 32'hDEADBEEF) begin failed++; $display("FAIL ld_A_data: got %h expected deadbeef", A); end
   endtask

   task automatic test_orphan();
      SelX = 3'd5; LdValid = 1'b1; LdTag = 3'd5; LdData = 32'hCAFE; tick();
      LdValid = 1'b0; #1;
      tests++; if (LdErr !== 1'b1) begin failed++; $display("FAIL orphan_err: got %b expected 1", LdErr); end
      tick();
      tests++; if (LdErr !== 1'b0) begin failed++; $display("FAIL orphan_pulse: got %b expected 0", LdErr); end
      tests++; if (A !== 32'h0) begin failed++; $display("FAIL orphan_r5: got %h expected 0", A); end
   endtask

   task automatic test_concurrent();
      MemInstruction = 2'b01; SelZ = 3'd6; SelX = 3'd1; SelY = 3'd1; tick();
      MemInstruction = 2'b10; AluData = 32'h222; SelZ = 3'd7;
      LdValid = 1'b1; LdTag = 3'd6; LdData = 32'h111; #1;
      tests++; if (Stall !== 1'b0) begin failed++; $display("FAIL cc_diff_stall: got %b expected 0", Stall); end
      tick();
      MemInstruction = 2'b00; LdValid = 1'b0; SelX = 3'd6; SelY = 3'd7; tick();
      tests++; if (A !== 32'h111) begin failed++; $display("FAIL cc_ld_r6: got %h expected 111", A); end
      tests++; if (B !== 32'h222) begin failed++; $display("FAIL cc_alu_r7: got %h expected 222", B); end
      tests++; if (Stall !== 1'b0) begin failed++; $display("FAIL cc_busy6_clr: got %b expected 0", Stall); end
      MemInstruction = 2'b01; SelZ = 3'd6; SelX = 3'd1; SelY = 3'd1; tick();
      MemInstruction = 2'b11; MemData = 32'h444; SelZ = 3'd6;
      LdValid = 1'b1; LdTag = 3'd6; LdData = 32'h333; #1;
      tests++; if (Stall !== !BYP) begin failed++; $display("FAIL cc_same_stall: got %b expected %b", Stall, !BYP); end
      tick();
      MemInstruction = 2'b00; LdValid = 1'b0; SelX = 3'd6; #1;
      tests++; if (Stall !== 1'b0) begin failed++; $display("FAIL cc_same_busy: got %b expected 0", Stall); end
      tests++; if (LdErr !== 1'b0) begin failed++; $display("FAIL cc_same_err: got %b expected 0", LdErr); end
      tick();
      tests++; if (A !== (BYP ? 32'h444 : 32'h333)) begin failed++; $display("FAIL cc_same_data: got %h expected %h", A, (BYP ? 32'h444 : 32'h333)); end
   endtask

   task automatic test_bypass();
      MemInstruction = 2'b10; AluData = 32'd77; SelZ = 3'd4; SelX = 3'd4; SelY = 3'd1; tick();
      MemInstruction = 2'b00; #1;
      tests++; if (A !== (BYP ? 32'd77 : 32'd0)) begin failed++; $display("FAIL byp_A_edge: got %0d expected %0d", A, (BYP ? 77 : 0)); end
      tick();
      tests++; if (A !== 32'd77) begin failed++; $display("FAIL byp_A_next: got %0d expected 77", A); end
   endtask

   task automatic test_reset_outstanding();
      MemInstruction = 2'b01; SelZ = 3'd3; SelX = 3'd1; SelY = 3'd1; tick();
      MemInstruction = 2'b00; SelY = 3'd3; LdValid = 1'b1; LdTag = 3'd5; LdData = 32'h55; tick();
      LdValid = 1'b0; #1;
      tests++; if (A !== 32'd44) begin failed++; $display("FAIL rso_pre_A: got %0d expected 44", A); end
      tests++; if (LdErr !== 1'b1) begin failed++; $display("FAIL rso_pre_err: got %b expected 1", LdErr); end
      tests++; if (Stall !== 1'b1) begin failed++; $display("FAIL rso_pre_stall: got %b expected 1", Stall); end
      #1; rst = 1'b1; #1;
      tests++; if (Stall !== 1'b0) begin failed++; $display("FAIL rso_stall: got %b expected 0", Stall); end
      tests++; if (A !== '0) begin failed++; $display("FAIL rso_A: got %h expected 0", A); end
      tests++; if (B !== '0) begin failed++; $display("FAIL rso_B: got %h expected 0", B); end
      tests++; if (LdErr !== 1'b0) begin failed++; $display("FAIL rso_err: got %b expected 0", LdErr); end
      #2; rst = 1'b0;
      LdValid = 1'b1; LdTag = 3'd3; LdData = 32'h77; SelX = 3'd3; tick();
      LdValid = 1'b0; #1;
      tests++; if (LdErr !== 1'b1) begin failed++; $display("FAIL rso_late_err: got %b expected 1", LdErr); end
      tick();
      tests++; if (A !== 32'h0) begin failed++; $display("FAIL rso_r3: got %h expected 0", A); end
   endtask

   task automatic test_r0_zero();
      zOp = 2'b11; zMem = 32'd99; zSelZ = 3'd0; tick();
      zSelZ = 3'd1; tick();
      zOp = 2'b00; zSelX = 3'd0; zSelY = 3'd1; tick();
      tests++; if (zA !== 32'd0) begin failed++; $display("FAIL r0z_read: got %0d expected 0", zA); end
      tests++; if (zB !== 32'd99) begin failed++; $display("FAIL r0z_r1: got %0d expected 99", zB); end
      zOp = 2'b01; zSelZ = 3'd0; #1;
      tests++; if (zStall !== 1'b0) begin failed++; $display("FAIL r0z_issue: got %b expected 0", zStall); end
      tick();
      zOp = 2'b00; #1;
      tests++; if (zStall !== 1'b0) begin failed++; $display("FAIL r0z_busy: got %b expected 0", zStall); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_load();
      test_orphan();
      test_concurrent();
      test_bypass();
      test_reset_outstanding();
      test_r0_zero();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
